// File: rtl/hazard_forwarding_ctrl.sv
// Hazard controller for the 5-stage RV32I core: shadows ID/EX, EX/MEM and MEM/WB destination info,
// drives EX operand forwarding selects and sequences load-use bubbles, dmem wait freezes and flushes.
module hazard_forwarding_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int WAIT_MAX   = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_access,
    input  logic                  ex_branch_taken,
    input  logic                  dmem_ready,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall_pc,
    output logic                  stall_if_id,
    output logic                  freeze_ex_mem,
    output logic                  bubble_id_ex,
    output logic                  flush_if_id,
    output logic                  err_timeout
);

    // state      | meaning
    // RUN        | normal flow; hazards detected combinationally
    // LOAD_STALL | one cycle after a load-use bubble; blocks re-detection of the same load
    // MEM_WAIT   | EX/MEM access waiting on dmem_ready; ID/EX and EX/MEM frozen
    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_access;
    } id_ex_t;

    // Later stages only need what forwarding and the wait detector look at.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_access;
    } ex_mem_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
    } mem_wb_t;

    state_t            state_q, state_d;
    id_ex_t            id_ex_q, id_ex_d;
    ex_mem_t           ex_mem_q, ex_mem_d;
    mem_wb_t           mem_wb_q, mem_wb_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;
    logic              mem_wait_req;
    logic              load_use;

    function automatic logic fwd_hit(input logic                  valid,
                                     input logic                  reg_write,
                                     input logic [REG_ADDR_W-1:0] rd,
                                     input logic [REG_ADDR_W-1:0] rs);
        return valid && reg_write && (rd != '0) && (rd == rs);
    endfunction

    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (fwd_hit(ex_mem_q.valid, ex_mem_q.reg_write, ex_mem_q.rd, id_ex_q.rs1)) begin
            fwd_a_sel = 2'b10;
        end else if (fwd_hit(mem_wb_q.valid, mem_wb_q.reg_write, mem_wb_q.rd, id_ex_q.rs1)) begin
            fwd_a_sel = 2'b01;
        end
        if (fwd_hit(ex_mem_q.valid, ex_mem_q.reg_write, ex_mem_q.rd, id_ex_q.rs2)) begin
            fwd_b_sel = 2'b10;
        end else if (fwd_hit(mem_wb_q.valid, mem_wb_q.reg_write, mem_wb_q.rd, id_ex_q.rs2)) begin
            fwd_b_sel = 2'b01;
        end
    end

    always_comb begin
        mem_wait_req = ex_mem_q.valid && ex_mem_q.mem_access && !dmem_ready;
        load_use     = id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.rd != '0) && id_valid &&
                       ((id_ex_q.rd == id_rs1) || (id_ex_q.rd == id_rs2));

        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        err_d         = err_q;
        stall_pc      = 1'b0;
        stall_if_id   = 1'b0;
        freeze_ex_mem = 1'b0;
        bubble_id_ex  = 1'b0;
        flush_if_id   = 1'b0;

        case (state_q)
            ST_MEM_WAIT: begin
                stall_pc      = 1'b1;
                stall_if_id   = 1'b1;
                freeze_ex_mem = 1'b1;
                if (dmem_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != CNT_W'(WAIT_MAX)) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                // The freeze starts in the detecting cycle so the access is held in MEM.
                if (mem_wait_req) begin
                    stall_pc      = 1'b1;
                    stall_if_id   = 1'b1;
                    freeze_ex_mem = 1'b1;
                    state_d       = ST_MEM_WAIT;
                    wait_cnt_d    = CNT_W'(1);
                end else if (ex_branch_taken) begin
                    flush_if_id  = 1'b1;
                    bubble_id_ex = 1'b1;
                    state_d      = ST_RUN;
                end else if ((state_q == ST_RUN) && load_use) begin
                    stall_pc     = 1'b1;
                    stall_if_id  = 1'b1;
                    bubble_id_ex = 1'b1;
                    state_d      = ST_LOAD_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
        endcase

        if (wait_cnt_d == CNT_W'(WAIT_MAX)) begin
            err_d = 1'b1;
        end
        err_timeout = err_q;
    end

    always_comb begin
        id_ex_d  = id_ex_q;
        ex_mem_d = ex_mem_q;
        mem_wb_d = '0;
        if (!freeze_ex_mem) begin
            mem_wb_d = '{valid: ex_mem_q.valid, rd: ex_mem_q.rd, reg_write: ex_mem_q.reg_write};
            ex_mem_d = '{valid: id_ex_q.valid, rd: id_ex_q.rd, reg_write: id_ex_q.reg_write,
                         mem_access: id_ex_q.mem_access};
            if (bubble_id_ex) begin
                id_ex_d = '0;
            end else begin
                id_ex_d = '{valid: id_valid, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                            reg_write: id_reg_write, mem_read: id_mem_read,
                            mem_access: id_mem_access};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            id_ex_q    <= '0;
            ex_mem_q   <= '0;
            mem_wb_q   <= '0;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_ex_q    <= id_ex_d;
            ex_mem_q   <= ex_mem_d;
            mem_wb_q   <= mem_wb_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_hazard_forwarding_ctrl.sv
// Directed bench for hazard_forwarding_ctrl: per-cycle expected output vectors are queued
// when the ID-stage stimulus is applied and compared when the outputs settle.
module tb_hazard_forwarding_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_reg_write, id_mem_read, id_mem_access;
    logic       ex_branch_taken, dmem_ready;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       stall_pc, stall_if_id, freeze_ex_mem, bubble_id_ex, flush_if_id, err_timeout;

    int errors = 0;
    int checks = 0;
    logic [9:0] exp_q[$];
    string      tag_q[$];

    // control bits: {stall_pc, stall_if_id, freeze_ex_mem, bubble_id_ex, flush_if_id, err_timeout}
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_LU   = 6'b110100;
    localparam logic [5:0] C_MW   = 6'b111000;
    localparam logic [5:0] C_BR   = 6'b000110;
    localparam logic [5:0] C_ERR  = 6'b000001;

    hazard_forwarding_ctrl #(.REG_ADDR_W(5), .WAIT_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_access(id_mem_access), .ex_branch_taken(ex_branch_taken),
        .dmem_ready(dmem_ready), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .freeze_ex_mem(freeze_ex_mem),
        .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                      input logic [5:0] ctl);
        return {fa, fb, ctl};
    endfunction

    task automatic push_exp(input string tag, input logic [9:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic pop_chk();
        logic [9:0] obs, exp;
        string tag;
        obs = {fwd_a_sel, fwd_b_sel, stall_pc, stall_if_id, freeze_ex_mem,
               bubble_id_ex, flush_if_id, err_timeout};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed=%b required=an entry", obs);
        end else begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
            end
        end
    endtask

    task automatic cyc(input string tag, input logic [9:0] exp);
        push_exp(tag, exp);
        #3;
        pop_chk();
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic rw, input logic mr, input logic ma);
        @(posedge clk);
        #1;
        id_valid      = v;
        id_rs1        = rs1;
        id_rs2        = rs2;
        id_rd         = rd;
        id_reg_write  = rw;
        id_mem_read   = mr;
        id_mem_access = ma;
    endtask

    task automatic go_alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        set_id(1'b1, rs1, rs2, rd, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic go_lw(input logic [4:0] rd, input logic [4:0] rs1);
        set_id(1'b1, rs1, 5'd0, rd, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic go_nop();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        ex_branch_taken = 1'b0;
        dmem_ready      = 1'b1;
        for (int i = 0; i < n; i++) go_nop();
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_access = 1'b0;
        ex_branch_taken = 1'b0; dmem_ready = 1'b1;
        #3;
        cyc("reset_state", mk(2'b00, 2'b00, C_NONE));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // add x5,x1,x2 ; sub x6,x5,x5
        go_alu(5'd5, 5'd1, 5'd2); cyc("b2b_c1", mk(2'b00, 2'b00, C_NONE));
        go_alu(5'd6, 5'd5, 5'd5); cyc("b2b_c2", mk(2'b00, 2'b00, C_NONE));
        go_nop();                 cyc("b2b_sub_ex", mk(2'b10, 2'b10, C_NONE));
        drain(3);

        // add x5,x1,x2 ; nop ; or x7,x5,x1
        go_alu(5'd5, 5'd1, 5'd2); cyc("d2_c1", mk(2'b00, 2'b00, C_NONE));
        go_nop();                 cyc("d2_c2", mk(2'b00, 2'b00, C_NONE));
        go_alu(5'd7, 5'd5, 5'd1); cyc("d2_c3", mk(2'b00, 2'b00, C_NONE));
        go_nop();                 cyc("d2_or_ex", mk(2'b01, 2'b00, C_NONE));
        drain(3);

        // same with rd=x0
        go_alu(5'd0, 5'd1, 5'd2); go_nop();
        go_alu(5'd7, 5'd0, 5'd1);
        go_nop();                 cyc("d2_x0_or_ex", mk(2'b00, 2'b00, C_NONE));
        drain(3);

        // add x5 ; add x5 ; and x8,x5,x5
        go_alu(5'd5, 5'd1, 5'd2);
        go_alu(5'd5, 5'd1, 5'd2); cyc("dbl_c2", mk(2'b00, 2'b00, C_NONE));
        go_alu(5'd8, 5'd5, 5'd5); cyc("dbl_c3", mk(2'b00, 2'b00, C_NONE));
        go_nop();                 cyc("dbl_and_ex", mk(2'b10, 2'b10, C_NONE));
        drain(3);

        // lw x3,0(x1) ; add x4,x3,x2
        go_lw(5'd3, 5'd1);        cyc("lu_c1", mk(2'b00, 2'b00, C_NONE));
        go_alu(5'd4, 5'd3, 5'd2); cyc("lu_detect", mk(2'b00, 2'b00, C_LU));
        go_alu(5'd4, 5'd3, 5'd2); cyc("lu_after_bubble", mk(2'b00, 2'b00, C_NONE));
        go_nop();                 cyc("lu_add_ex", mk(2'b01, 2'b00, C_NONE));
        drain(3);

        // taken branch in the same cycle as a load-use
        go_lw(5'd3, 5'd1);
        go_alu(5'd4, 5'd3, 5'd2); ex_branch_taken = 1'b1;
        cyc("br_vs_lu", mk(2'b00, 2'b00, C_BR));
        go_nop(); ex_branch_taken = 1'b0;
        cyc("br_after", mk(2'b00, 2'b00, C_NONE));
        drain(3);

        // lw with dmem_ready low for 3 cycles; a branch during the wait is ignored
        go_lw(5'd9, 5'd1);
        go_nop();                 cyc("mw_c2", mk(2'b00, 2'b00, C_NONE));
        go_nop(); dmem_ready = 1'b0; cyc("mw_w1", mk(2'b00, 2'b00, C_MW));
        go_nop(); ex_branch_taken = 1'b1; cyc("mw_w2_branch", mk(2'b00, 2'b00, C_MW));
        go_nop(); ex_branch_taken = 1'b0; cyc("mw_w3", mk(2'b00, 2'b00, C_MW));
        go_nop(); dmem_ready = 1'b1; cyc("mw_exit", mk(2'b00, 2'b00, C_MW));
        go_nop();                 cyc("mw_run", mk(2'b00, 2'b00, C_NONE));
        drain(3);

        // dmem_ready low for 20 cycles: timeout
        go_lw(5'd9, 5'd1);
        go_nop();
        for (int k = 0; k < 20; k++) begin
            go_nop(); dmem_ready = 1'b0;
            cyc($sformatf("to_w%0d", k), mk(2'b00, 2'b00, (k >= 15) ? (C_MW | C_ERR) : C_MW));
        end
        go_nop(); dmem_ready = 1'b1; cyc("to_exit", mk(2'b00, 2'b00, C_MW | C_ERR));
        go_nop();                 cyc("to_sticky", mk(2'b00, 2'b00, C_NONE | C_ERR));
        drain(3);

        // reset during MEM_WAIT
        go_lw(5'd9, 5'd1);
        go_nop();
        go_nop(); dmem_ready = 1'b0; cyc("rst_pre", mk(2'b00, 2'b00, C_MW | C_ERR));
        go_nop();                 cyc("rst_pre2", mk(2'b00, 2'b00, C_MW | C_ERR));
        #1;
        rst_n = 1'b0;
        push_exp("rst_mid_wait", mk(2'b00, 2'b00, C_NONE));
        #1;
        pop_chk();
        @(negedge clk);
        rst_n = 1'b1;
        go_nop();                 cyc("rst_post", mk(2'b00, 2'b00, C_NONE));
        drain(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
